// File: rtl/alu16.sv
// ---------------------------------------------------------------------------
// alu16 -- two's-complement ALU for the 16-bit CPU datapath
//
// Result and N/Z/P flags are purely combinational from a, b and alu_op. A
// condition-code register captures the flags for branch logic when cc_en is
// high on a rising clk edge, unless the opcode is reserved.
//
// Ports:
//   clk     in   system clock, rising edge updates the CC register
//   rst     in   asynchronous active-high reset of the CC register (-> Z)
//   a, b    in   WIDTH-bit operands
//   alu_op  in   4-bit operation select
//   cc_en   in   latch {N,Z,P} into the CC register on the next rising edge
//   result  out  combinational result
//   N, Z, P out  combinational flags (exactly one is high)
//   cc_n, cc_z, cc_p out  registered flags
// ---------------------------------------------------------------------------
module alu16 #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_op,
   input  logic             cc_en,
   output logic [WIDTH-1:0] result,
   output logic             N,
   output logic             Z,
   output logic             P,
   output logic             cc_n,
   output logic             cc_z,
   output logic             cc_p
);

   localparam int SHW = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_CMP  = 4'b0100;
   localparam logic [3:0] OP_XOR  = 4'b0101;
   localparam logic [3:0] OP_NOT  = 4'b0110;
   localparam logic [3:0] OP_SHL  = 4'b0111;
   localparam logic [3:0] OP_SHR  = 4'b1000;
   localparam logic [3:0] OP_SRA  = 4'b1001;
   localparam logic [3:0] OP_PASS = 4'b1010;

   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_diff;
   logic [SHW-1:0]   w_shamt;
   logic [WIDTH-1:0] w_result;
   logic [WIDTH-1:0] w_flag_val;
   logic             w_op_valid;
   logic             w_n;
   logic             w_z;
   logic             w_p;
   logic [2:0]       r_cc;

   // Both adders wrap mod 2^WIDTH; flags follow the wrapped value.
   assign w_sum   = a + b;
   assign w_diff  = a - b;
   // Only the low bits of b select the shift distance; upper bits are ignored.
   assign w_shamt = b[SHW-1:0];

   always_comb begin
      w_result   = '0;
      w_op_valid = 1'b1;
      unique case (alu_op)
         OP_ADD:  w_result = w_sum;
         OP_SUB:  w_result = w_diff;
         OP_AND:  w_result = a & b;
         OP_OR:   w_result = a | b;
         OP_CMP:  w_result = '0;
         OP_XOR:  w_result = a ^ b;
         OP_NOT:  w_result = ~a;
         OP_SHL:  w_result = a << w_shamt;
         OP_SHR:  w_result = a >> w_shamt;
         OP_SRA:  w_result = $unsigned($signed(a) >>> w_shamt);
         OP_PASS: w_result = b;
         default: begin
            w_result   = '0;
            w_op_valid = 1'b0;
         end
      endcase
   end

   // CMP reports the flags of a-b while its result reads zero; for every
   // other opcode (reserved included) the flags describe the result itself.
   always_comb begin
      w_flag_val = w_result;
      if (alu_op == OP_CMP) begin
         w_flag_val = w_diff;
      end
   end

   assign w_n = w_flag_val[WIDTH-1];
   assign w_z = (w_flag_val == '0);
   assign w_p = ~w_n & ~w_z;

   assign result = w_result;
   assign N      = w_n;
   assign Z      = w_z;
   assign P      = w_p;

   // Reserved opcodes never disturb the CC register, even with cc_en high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cc <= 3'b010;
      end else if (cc_en && w_op_valid) begin
         r_cc <= {w_n, w_z, w_p};
      end
   end

   assign cc_n = r_cc[2];
   assign cc_z = r_cc[1];
   assign cc_p = r_cc[0];

endmodule

// File: tb/tb_alu16.sv
module tb_alu16;

   logic        clk;
   logic        rst;
   logic [15:0] a;
   logic [15:0] b;
   logic [3:0]  alu_op;
   logic        cc_en;
   logic [15:0] result;
   logic        N, Z, P;
   logic        cc_n, cc_z, cc_p;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      bit          is_cc;
      logic [15:0] res;
      logic [2:0]  nzp;
   } sb_t;

   sb_t sb[$];

   localparam logic [2:0] FN = 3'b100;
   localparam logic [2:0] FZ = 3'b010;
   localparam logic [2:0] FP = 3'b001;

   alu16 #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .alu_op(alu_op), .cc_en(cc_en),
      .result(result), .N(N), .Z(Z), .P(P),
      .cc_n(cc_n), .cc_z(cc_z), .cc_p(cc_p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic push(input string tag, input bit is_cc,
                       input logic [15:0] eres, input logic [2:0] enzp);
      sb_t item;
      item.tag   = tag;
      item.is_cc = is_cc;
      item.res   = eres;
      item.nzp   = enzp;
      sb.push_back(item);
   endtask

   task automatic compare();
      sb_t item;
      logic [2:0] obs;
      checks++;
      assert (sb.size() != 0) else begin
         errors++;
         $error("FAIL scoreboard_empty: got size 0 expected >0");
      end
      if (sb.size() != 0) begin
         item = sb.pop_front();
         if (item.is_cc) begin
            obs = {cc_n, cc_z, cc_p};
            checks++;
            assert (obs === item.nzp) else begin
               errors++;
               $error("FAIL %s cc: got %b expected %b", item.tag, obs, item.nzp);
            end
         end else begin
            obs = {N, Z, P};
            checks++;
            assert (result === item.res) else begin
               errors++;
               $error("FAIL %s result: got %h expected %h", item.tag, result, item.res);
            end
            checks++;
            assert (obs === item.nzp) else begin
               errors++;
               $error("FAIL %s nzp: got %b expected %b", item.tag, obs, item.nzp);
            end
         end
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [15:0] ia, input logic [15:0] ib);
      alu_op = op;
      a      = ia;
      b      = ib;
   endtask

   task automatic comb(input string tag, input logic [3:0] op,
                       input logic [15:0] ia, input logic [15:0] ib,
                       input logic [15:0] eres, input logic [2:0] enzp);
      @(negedge clk);
      drive(op, ia, ib);
      push(tag, 1'b0, eres, enzp);
      #1;
      compare();
   endtask

   task automatic cc_check(input string tag, input logic [2:0] enzp);
      push(tag, 1'b1, 16'h0000, enzp);
      compare();
   endtask

   initial begin
      rst    = 1'b1;
      cc_en  = 1'b0;
      drive(4'b0000, 16'h0000, 16'h0000);
      #3;
      cc_check("reset_idle", FZ);

      @(negedge clk);
      rst = 1'b0;

      comb("add_10_5",    4'b0000, 16'd10,   16'd5,    16'h000F, FP);
      comb("add_ffff_1",  4'b0000, 16'hFFFF, 16'h0001, 16'h0000, FZ);
      comb("add_wrap_neg",4'b0000, 16'h8000, 16'hFFFF, 16'h7FFF, FP);
      comb("add_wrap_pos",4'b0000, 16'h7FFF, 16'h0001, 16'h8000, FN);
      comb("sub_10_5",    4'b0001, 16'd10,   16'd5,    16'h0005, FP);
      comb("sub_5_5",     4'b0001, 16'd5,    16'd5,    16'h0000, FZ);
      comb("sub_3_7",     4'b0001, 16'd3,    16'd7,    16'hFFFC, FN);
      comb("sub_8000_1",  4'b0001, 16'h8000, 16'h0001, 16'h7FFF, FP);
      comb("and_f0",      4'b0010, 16'hF0F0, 16'h0FF0, 16'h00F0, FP);
      comb("and_zero",    4'b0010, 16'h0000, 16'hFFFF, 16'h0000, FZ);
      comb("or_8001",     4'b0011, 16'h8000, 16'h0001, 16'h8001, FN);
      comb("or_zero",     4'b0011, 16'h0000, 16'h0000, 16'h0000, FZ);
      comb("xor_ff00",    4'b0101, 16'hFFFF, 16'h00FF, 16'hFF00, FN);
      comb("not_0",       4'b0110, 16'h0000, 16'h1234, 16'hFFFF, FN);
      comb("cmp_eq",      4'b0100, 16'd7,    16'd7,    16'h0000, FZ);
      comb("cmp_lt",      4'b0100, 16'd3,    16'd8,    16'h0000, FN);
      comb("cmp_gt",      4'b0100, 16'd9,    16'd1,    16'h0000, FP);
      comb("shl_b13",     4'b0111, 16'h0001, 16'h0013, 16'h0008, FP);
      comb("shl_by0",     4'b0111, 16'h1234, 16'h0010, 16'h1234, FP);
      comb("shr_15",      4'b1000, 16'h8000, 16'd15,   16'h0001, FP);
      comb("sra_15",      4'b1001, 16'h8000, 16'd15,   16'hFFFF, FN);
      comb("sra_4",       4'b1001, 16'h8420, 16'h0004, 16'hF842, FN);
      comb("pass",        4'b1010, 16'hAAAA, 16'h1234, 16'h1234, FP);
      comb("rsv_1111",    4'b1111, 16'h8000, 16'h0001, 16'h0000, FZ);
      comb("rsv_1011",    4'b1011, 16'hFFFF, 16'hFFFF, 16'h0000, FZ);

      cc_check("cc_held_cc_en0", FZ);

      @(negedge clk);
      drive(4'b0100, 16'd3, 16'd8);
      cc_en = 1'b1;
      @(posedge clk); #1;
      cc_check("cc_cmp_n", FN);

      @(negedge clk);
      cc_en = 1'b0;
      drive(4'b0000, 16'd10, 16'd5);
      @(posedge clk); #1;
      cc_check("cc_hold_en0", FN);

      @(negedge clk);
      cc_en = 1'b1;
      drive(4'b1111, 16'd0, 16'd0);
      @(posedge clk); #1;
      cc_check("cc_hold_rsv", FN);

      @(negedge clk);
      drive(4'b0000, 16'd10, 16'd5);
      @(posedge clk); #1;
      cc_check("cc_add_p", FP);

      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      cc_check("cc_async_rst", FZ);

      comb("cmp_during_rst", 4'b0100, 16'd3, 16'd8, 16'h0000, FN);
      @(posedge clk); #1;
      cc_check("cc_rst_dominates", FZ);

      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      cc_check("cc_after_release", FN);

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_drain: got %0d expected 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu16.md
Name: alu16

Overview:
- 16-bit two's-complement ALU for the 16-bit ISA CPU datapath.
- Result and N/Z/P condition flags are purely combinational from the operands and opcode.
- A clocked condition-code register latches the flags for branch logic.
- Sits between the register-file read ports and the writeback mux.

Parameters:
- WIDTH, 16, operand/result width; all behaviour below is stated for 16.

Ports:
- clk  input  1  system clock; rising edge updates the condition-code register
- rst  input  1  asynchronous, active-high reset of the condition-code register
- a  input  16  operand A (two's complement)
- b  input  16  operand B (two's complement)
- alu_op  input  4  operation select
- cc_en  input  1  when high, the flags are latched into the CC register on the next rising clk edge
- result  output  16  combinational operation result
- N  output  1  combinational negative flag
- Z  output  1  combinational zero flag
- P  output  1  combinational positive flag
- cc_n  output  1  registered N
- cc_z  output  1  registered Z
- cc_p  output  1  registered P

Behaviour:
- Opcodes; result is mod 2^16, no carry or overflow outputs:
  - 0000 ADD: a+b
  - 0001 SUB: a-b
  - 0010 AND: a&b
  - 0011 OR: a|b
  - 0100 CMP: result=16'h0000; flags computed from a-b
  - 0101 XOR: a^b
  - 0110 NOT: ~a
  - 0111 SHL: a << b[3:0]
  - 1000 SHR: logical a >> b[3:0]
  - 1001 SRA: arithmetic a >>> b[3:0]
  - 1010 PASS: b
  - 1011-1111 reserved: result=0, flags N=0 Z=1 P=0, and the CC register is never updated, even with cc_en=1
- Flag value F is the result for all opcodes except CMP, where F=a-b.
  - N=F[15]
  - Z=(F==0)
  - P=~N&~Z
  - Exactly one of N/Z/P is high at all times.
- Overflow wraps silently, and flags follow the wrapped value:
  - 7FFF+1 gives 8000, N=1.
  - 8000-1 gives 7FFF, P=1.
- Combinational path: result/N/Z/P settle within the same cycle as input changes. They are independent of clk and rst, and no latches are inferred.
- CC register:
  - On rising clk with cc_en=1 and a non-reserved opcode: {cc_n,cc_z,cc_p} <= {N,Z,P}.
  - Otherwise the register holds.
- Reset:
  - rst=1 forces cc_n=0, cc_z=1, cc_p=0 immediately, without waiting for a clock edge.
  - Reset dominates a simultaneous clk edge with cc_en=1.
  - Deasserting rst mid-operation takes effect at the next qualifying edge.
  - Combinational outputs are unaffected by rst.
- Shift amount uses b[3:0] only; b[15:4] is ignored. A shift of 0 returns a.

Test Plan:
- ADD:
  - a=10, b=5 -> 000F, P=1
  - a=FFFF, b=1 -> 0000, Z=1
  - a=8000, b=FFFF -> 7FFF, P=1 (wrap)
  - a=7FFF, b=1 -> 8000, N=1
- SUB:
  - a=10, b=5 -> 0005, P=1
  - a=5, b=5 -> 0000, Z=1
  - a=3, b=7 -> FFFC, N=1
  - a=8000, b=1 -> 7FFF, P=1
- Logic:
  - AND F0F0&0FF0 -> 00F0, P=1
  - AND 0000&FFFF -> 0000, Z=1
  - OR 8000|0001 -> 8001, N=1
  - OR 0|0 -> 0000, Z=1
  - XOR FFFF^00FF -> FF00, N=1
  - NOT 0000 -> FFFF, N=1
- CMP:
  - 7 vs 7 -> Z=1
  - 3 vs 8 -> N=1
  - 9 vs 1 -> P=1
  - result must read 0000 in all three cases
- Shifts, PASS and reserved:
  - SHL 0001 by b=0x0013 -> 0008 (only b[3:0]=3 used)
  - SHR 8000 by 15 -> 0001
  - SRA 8000 by 15 -> FFFF
  - PASS b=1234 -> 1234
  - op 1111 -> 0000, Z=1, CC unchanged
- CC register:
  - Assert rst with clk idle -> cc_z=1 immediately.
  - Release rst, run CMP 3 vs 8 with cc_en=1, one edge -> cc_n=1.
  - cc_en=0 with a new op -> CC holds.
  - Assert rst mid-sequence -> CC returns to Z asynchronously.
